// File: rtl/freq_meter_mc_if.sv
// freq_meter_mc_if: result port of the multi-channel frequency meter.
// Carries one measurement result per valid/ready handshake.
//   res_valid   - a result is held and offered to the consumer
//   res_ready   - consumer accepts the offered result this cycle
//   res_ch      - source channel of the result
//   res_sig_cnt - whole signal periods inside the window
//   res_ref_cnt - clk cycles inside the window
//   res_flags   - bit1 timeout, bit0 counter saturated
interface freq_meter_mc_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32
) ();
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             res_valid;
  logic             res_ready;
  logic [CH_W-1:0]  res_ch;
  logic [CNT_W-1:0] res_sig_cnt;
  logic [CNT_W-1:0] res_ref_cnt;
  logic [1:0]       res_flags;

  modport master (
    output res_valid, res_ch, res_sig_cnt, res_ref_cnt, res_flags,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_ch, res_sig_cnt, res_ref_cnt, res_flags,
    output res_ready
  );
endinterface

// File: rtl/freq_meter_mc.sv
// freq_meter_mc: multi-channel equal-precision frequency/period meter.
// Each channel opens and closes its window on rising edges of its own input,
// counting whole signal periods and clk cycles; finished results are served
// round-robin through a single registered valid/ready slot.
//   clk_200M  - single measurement clock
//   rst       - synchronous active-high reset
//   sig_in    - asynchronous signals under test, one per channel
//   ch_en     - per-channel enable, low forces the channel idle
//   start     - per-channel one-cycle start pulse
//   cont_mode - 1 re-arms a channel after each result, 0 single-shot
//   gate_len  - minimum window length in clk cycles, sampled on every arm
//   busy      - channel is not idle
//   res       - result port (master side)
module freq_meter_mc #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 200_000_000
) (
  input  logic              clk_200M,
  input  logic              rst,
  input  logic [NUM_CH-1:0] sig_in,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] start,
  input  logic              cont_mode,
  input  logic [CNT_W-1:0]  gate_len,
  output logic [NUM_CH-1:0] busy,
  freq_meter_mc_if.master   res
);
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned SUM_W = CH_W + 1;
  localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_MEAS = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  logic [NUM_CH-1:0] sig_meta, sig_sync, sig_prev, rise;

  logic [1:0]       state     [NUM_CH];
  logic [1:0]       state_nxt [NUM_CH];
  logic [CNT_W-1:0] gate_r    [NUM_CH];
  logic [CNT_W-1:0] gate_nxt  [NUM_CH];
  logic [CNT_W-1:0] sig_cnt   [NUM_CH];
  logic [CNT_W-1:0] sig_nxt   [NUM_CH];
  logic [CNT_W-1:0] ref_cnt   [NUM_CH];
  logic [CNT_W-1:0] ref_nxt   [NUM_CH];
  logic [TO_W-1:0]  idle_cnt  [NUM_CH];
  logic [TO_W-1:0]  idle_nxt  [NUM_CH];
  logic [1:0]       flags     [NUM_CH];
  logic [1:0]       flags_nxt [NUM_CH];
  logic [NUM_CH-1:0] busy_nxt;
  logic [NUM_CH-1:0] grant;

  logic             load_en;
  logic             found;
  logic [CH_W-1:0]  ld_ch;
  logic [CH_W-1:0]  ptr, ptr_nxt;
  logic             valid_q;
  logic [CH_W-1:0]  ch_q;
  logic [CNT_W-1:0] sig_q, ref_q;
  logic [1:0]       flags_q;

  // Two-flop synchroniser plus compare register for rising-edge detection
  always_ff @(posedge clk_200M) begin
    if (rst) begin
      sig_meta <= '0;
      sig_sync <= '0;
      sig_prev <= '0;
    end else begin
      sig_meta <= sig_in;
      sig_sync <= sig_meta;
      sig_prev <= sig_sync;
    end
  end

  assign rise = sig_sync & ~sig_prev;

  // Channel state register
  always_ff @(posedge clk_200M) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state[i]    <= S_IDLE;
        gate_r[i]   <= '0;
        sig_cnt[i]  <= '0;
        ref_cnt[i]  <= '0;
        idle_cnt[i] <= '0;
        flags[i]    <= '0;
      end
      busy <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state[i]    <= state_nxt[i];
        gate_r[i]   <= gate_nxt[i];
        sig_cnt[i]  <= sig_nxt[i];
        ref_cnt[i]  <= ref_nxt[i];
        idle_cnt[i] <= idle_nxt[i];
        flags[i]    <= flags_nxt[i];
      end
      busy <= busy_nxt;
    end
  end

  // Channel next-state: IDLE -> ARM -> MEAS -> DONE
  always_comb begin
    logic [CNT_W-1:0] ref_inc;
    logic [CNT_W-1:0] sig_inc;
    logic             sat;
    ref_inc  = '0;
    sig_inc  = '0;
    sat      = 1'b0;
    busy_nxt = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      state_nxt[i] = state[i];
      gate_nxt[i]  = gate_r[i];
      sig_nxt[i]   = sig_cnt[i];
      ref_nxt[i]   = ref_cnt[i];
      idle_nxt[i]  = idle_cnt[i];
      flags_nxt[i] = flags[i];

      // Counters clamp at all-ones; a clamped increment marks saturation
      ref_inc = (ref_cnt[i] == CNT_MAX) ? CNT_MAX : ref_cnt[i] + CNT_W'(1);
      if (!rise[i])
        sig_inc = sig_cnt[i];
      else
        sig_inc = (sig_cnt[i] == CNT_MAX) ? CNT_MAX : sig_cnt[i] + CNT_W'(1);
      sat = (ref_cnt[i] == CNT_MAX) || (rise[i] && (sig_cnt[i] == CNT_MAX));

      case (state[i])
        S_IDLE: begin
          if (start[i]) begin
            state_nxt[i] = S_ARM;
            gate_nxt[i]  = gate_len;
            idle_nxt[i]  = '0;
            sig_nxt[i]   = '0;
            ref_nxt[i]   = '0;
            flags_nxt[i] = '0;
          end
        end
        S_ARM: begin
          if (rise[i]) begin
            state_nxt[i] = S_MEAS;
            idle_nxt[i]  = '0;
          end else if (idle_cnt[i] == TO_LAST) begin
            state_nxt[i] = S_DONE;
            flags_nxt[i] = 2'b10;
          end else begin
            idle_nxt[i] = idle_cnt[i] + TO_W'(1);
          end
        end
        S_MEAS: begin
          ref_nxt[i]      = ref_inc;
          sig_nxt[i]      = sig_inc;
          flags_nxt[i][0] = flags[i][0] | sat;
          // An edge wins over a simultaneous timeout expiry
          if (rise[i]) begin
            idle_nxt[i] = '0;
            if (ref_inc >= gate_r[i]) state_nxt[i] = S_DONE;
          end else if (idle_cnt[i] == TO_LAST) begin
            state_nxt[i]    = S_DONE;
            flags_nxt[i][1] = 1'b1;
          end else begin
            idle_nxt[i] = idle_cnt[i] + TO_W'(1);
          end
        end
        S_DONE: begin
          if (grant[i]) begin
            if (cont_mode) begin
              state_nxt[i] = S_ARM;
              gate_nxt[i]  = gate_len;
              idle_nxt[i]  = '0;
              sig_nxt[i]   = '0;
              ref_nxt[i]   = '0;
              flags_nxt[i] = '0;
            end else begin
              state_nxt[i] = S_IDLE;
            end
          end
        end
        default: state_nxt[i] = S_IDLE;
      endcase

      if (!ch_en[i]) state_nxt[i] = S_IDLE;
      busy_nxt[i] = (state_nxt[i] != S_IDLE);
    end
  end

  // Round-robin pick of the next DONE channel, starting at ptr
  always_comb begin
    logic [SUM_W-1:0] sum;
    sum     = '0;
    found   = 1'b0;
    ld_ch   = '0;
    grant   = '0;
    load_en = !valid_q || res.res_ready;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      sum = {1'b0, ptr} + SUM_W'(k);
      if (sum >= SUM_W'(NUM_CH)) sum = sum - SUM_W'(NUM_CH);
      if (!found && (state[sum[CH_W-1:0]] == S_DONE) && ch_en[sum[CH_W-1:0]]) begin
        found = 1'b1;
        ld_ch = sum[CH_W-1:0];
      end
    end
    ptr_nxt = (ld_ch == CH_W'(NUM_CH - 1)) ? '0 : ld_ch + CH_W'(1);
    if (load_en && found) grant[ld_ch] = 1'b1;
  end

  // Single-slot output register; refills in the same cycle as a handshake
  always_ff @(posedge clk_200M) begin
    if (rst) begin
      valid_q <= 1'b0;
      ch_q    <= '0;
      sig_q   <= '0;
      ref_q   <= '0;
      flags_q <= '0;
      ptr     <= '0;
    end else if (load_en) begin
      valid_q <= found;
      if (found) begin
        ch_q    <= ld_ch;
        sig_q   <= sig_cnt[ld_ch];
        ref_q   <= ref_cnt[ld_ch];
        flags_q <= flags[ld_ch];
        ptr     <= ptr_nxt;
      end
    end
  end

  assign res.res_valid   = valid_q;
  assign res.res_ch      = ch_q;
  assign res.res_sig_cnt = sig_q;
  assign res.res_ref_cnt = ref_q;
  assign res.res_flags   = flags_q;
endmodule

// File: tb/tb_freq_meter_mc.sv
// tb_freq_meter_mc: directed bench for freq_meter_mc.
// dut_a: 4 channels, 32-bit counters, TIMEOUT 50 (exact counts, timeout,
// arbitration/backpressure). dut_b: 2 channels, 8-bit counters (continuous
// mode, saturation, reset mid-window). Both share one periodic stimulus.
`timescale 1ns/1ps
module tb_freq_meter_mc;
  logic clk_200M = 1'b0;
  always #2.5 clk_200M = ~clk_200M;

  logic        rst;
  logic        sig_src;
  logic        gen_en, man_sig;
  int          per, ph;
  longint      cyc = 0;
  int          n_chk = 0, n_pass = 0;

  logic [3:0]  ch_en_a, start_a, busy_a;
  logic        cont_a, ready_a;
  logic [31:0] gate_a;
  logic [1:0]  ch_en_b, start_b, busy_b;
  logic        cont_b, ready_b;
  logic [7:0]  gate_b;
  wire  [3:0]  sig_a = {4{sig_src}};
  wire  [1:0]  sig_b = {1'b0, sig_src};

  freq_meter_mc_if #(.NUM_CH(4), .CNT_W(32)) res_a ();
  freq_meter_mc_if #(.NUM_CH(2), .CNT_W(8))  res_b ();
  assign res_a.res_ready = ready_a;
  assign res_b.res_ready = ready_b;

  freq_meter_mc #(.NUM_CH(4), .CNT_W(32), .TIMEOUT(50)) dut_a (
    .clk_200M(clk_200M), .rst(rst), .sig_in(sig_a), .ch_en(ch_en_a),
    .start(start_a), .cont_mode(cont_a), .gate_len(gate_a), .busy(busy_a),
    .res(res_a)
  );

  freq_meter_mc #(.NUM_CH(2), .CNT_W(8), .TIMEOUT(1000)) dut_b (
    .clk_200M(clk_200M), .rst(rst), .sig_in(sig_b), .ch_en(ch_en_b),
    .start(start_b), .cont_mode(cont_b), .gate_len(gate_b), .busy(busy_b),
    .res(res_b)
  );

  always @(posedge clk_200M) cyc <= cyc + 1;

  // Periodic source: rising edge every per cycles, or a manual level
  always @(negedge clk_200M) begin
    if (gen_en) begin
      ph = (ph + 1 >= per) ? 0 : ph + 1;
      sig_src = (ph < per / 2);
    end else begin
      ph = 0;
      sig_src = man_sig;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1 ms");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic get_res(input bit use_b, input int budget, output bit ok,
                         output logic [63:0] ch, output logic [63:0] sig,
                         output logic [63:0] rc, output logic [63:0] fl,
                         output longint t);
    ok = 1'b0; ch = '0; sig = '0; rc = '0; fl = '0; t = 0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk_200M);
      if (!use_b && res_a.res_valid) begin
        ok = 1'b1; t = cyc;
        ch = 64'(res_a.res_ch); sig = 64'(res_a.res_sig_cnt);
        rc = 64'(res_a.res_ref_cnt); fl = 64'(res_a.res_flags);
      end else if (use_b && res_b.res_valid) begin
        ok = 1'b1; t = cyc;
        ch = 64'(res_b.res_ch); sig = 64'(res_b.res_sig_cnt);
        rc = 64'(res_b.res_ref_cnt); fl = 64'(res_b.res_flags);
      end
    end
  endtask

  task automatic expect_res(input string tag, input bit use_b, input int budget,
                            input logic [63:0] e_ch, input logic [63:0] e_sig,
                            input logic [63:0] e_ref, input logic [63:0] e_fl,
                            output longint t);
    bit ok;
    logic [63:0] ch, sig, rc, fl;
    get_res(use_b, budget, ok, ch, sig, rc, fl, t);
    check({tag, "_valid"}, 64'(ok), 64'd1);
    check({tag, "_ch"}, ch, e_ch);
    check({tag, "_sig"}, sig, e_sig);
    check({tag, "_ref"}, rc, e_ref);
    check({tag, "_flags"}, fl, e_fl);
  endtask

  task automatic pulse_a(input logic [3:0] m, output longint t0);
    start_a = m; t0 = cyc;
    @(negedge clk_200M);
    start_a = '0;
  endtask

  task automatic pulse_b(input logic [1:0] m);
    start_b = m;
    @(negedge clk_200M);
    start_b = '0;
  endtask

  initial begin
    longint t0, t;
    int changes, vcnt;
    logic [63:0] p_ch, p_sig, p_ref;
    bit ok;
    logic [63:0] d_ch, d_sig, d_ref, d_fl;

    rst = 1'b1; gen_en = 1'b0; man_sig = 1'b0; per = 10; ph = 0; sig_src = 1'b0;
    ch_en_a = 4'hF; start_a = '0; cont_a = 1'b0; ready_a = 1'b1; gate_a = 32'd0;
    ch_en_b = 2'b11; start_b = '0; cont_b = 1'b0; ready_b = 1'b1; gate_b = 8'd0;
    repeat (4) @(negedge clk_200M);

    // Reset state
    check("rst_busy_a", 64'(busy_a), 64'd0);
    check("rst_valid_a", 64'(res_a.res_valid), 64'd0);
    check("rst_ch_a", 64'(res_a.res_ch), 64'd0);
    check("rst_sig_a", 64'(res_a.res_sig_cnt), 64'd0);
    check("rst_ref_a", 64'(res_a.res_ref_cnt), 64'd0);
    check("rst_flags_a", 64'(res_a.res_flags), 64'd0);
    check("rst_busy_b", 64'(busy_b), 64'd0);
    rst = 1'b0;

    // Arbitration and backpressure: all four finish together (period 10, gate 20)
    gen_en = 1'b1; per = 10;
    repeat (30) @(negedge clk_200M);
    gate_a = 32'd20; ready_a = 1'b0;
    pulse_a(4'hF, t0);
    get_res(1'b0, 200, ok, p_ch, p_sig, p_ref, d_fl, t);
    check("bp_first_valid", 64'(ok), 64'd1);
    changes = 0;
    repeat (20) begin
      @(negedge clk_200M);
      if (!res_a.res_valid || 64'(res_a.res_ch) != p_ch ||
          64'(res_a.res_sig_cnt) != p_sig || 64'(res_a.res_ref_cnt) != p_ref)
        changes++;
    end
    check("bp_stable", 64'(changes), 64'd0);
    check("bp_ch", p_ch, 64'd0);
    check("bp_sig", p_sig, 64'd2);
    check("bp_ref", p_ref, 64'd20);
    check("bp_busy", 64'(busy_a), 64'b1110);
    // Disabling ch3 while it waits in DONE discards its result
    ch_en_a = 4'b0111;
    @(negedge clk_200M);
    check("bp_busy_dis", 64'(busy_a), 64'b0110);
    ready_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rr_valid%0d", k), 64'(res_a.res_valid), 64'd1);
      check($sformatf("rr_ch%0d", k), 64'(res_a.res_ch), 64'(k));
      check($sformatf("rr_ref%0d", k), 64'(res_a.res_ref_cnt), 64'd20);
      @(negedge clk_200M);
    end
    check("rr_drained", 64'(res_a.res_valid), 64'd0);
    ch_en_a = 4'hF;

    // Exact count: period 10, gate 100, single-shot
    gate_a = 32'd100;
    pulse_a(4'b0001, t0);
    check("t1_busy", 64'(busy_a), 64'b0001);
    expect_res("t1", 1'b0, 400, 64'd0, 64'd10, 64'd100, 64'd0, t);
    repeat (2) @(negedge clk_200M);
    check("t1_idle", 64'(busy_a), 64'd0);

    // Non-integer period 7; gate change mid-window is ignored
    per = 7;
    repeat (20) @(negedge clk_200M);
    pulse_a(4'b0001, t0);
    repeat (20) @(negedge clk_200M);
    gate_a = 32'd0;
    expect_res("t2", 1'b0, 400, 64'd0, 64'd15, 64'd105, 64'd0, t);
    pulse_a(4'b0001, t0);
    expect_res("t2g0", 1'b0, 200, 64'd0, 64'd1, 64'd7, 64'd0, t);

    // Timeout while armed: 50 armed cycles, then DONE and load (start cycle + 52)
    gen_en = 1'b0; man_sig = 1'b0;
    repeat (10) @(negedge clk_200M);
    gate_a = 32'd100;
    pulse_a(4'b0010, t0);
    expect_res("to_arm", 1'b0, 200, 64'd1, 64'd0, 64'd0, 64'd2, t);
    check("to_lat", 64'(t - t0), 64'd52);
    // One opening edge then silence: 50 measured cycles
    pulse_a(4'b0100, t0);
    repeat (5) @(negedge clk_200M);
    man_sig = 1'b1;
    repeat (3) @(negedge clk_200M);
    man_sig = 1'b0;
    expect_res("to_meas", 1'b0, 200, 64'd2, 64'd0, 64'd50, 64'd2, t);

    // Continuous mode, 8-bit counters: period 3, gate 250 -> 84 periods, 252 cycles
    gen_en = 1'b1; per = 3;
    repeat (20) @(negedge clk_200M);
    cont_b = 1'b1; gate_b = 8'd250;
    pulse_b(2'b01);
    for (int k = 0; k < 3; k++)
      expect_res($sformatf("cont%0d", k), 1'b1, 700, 64'd0, 64'd84, 64'd252, 64'd0, t);
    ch_en_b = 2'b00;
    repeat (2) @(negedge clk_200M);
    check("cont_dis_busy", 64'(busy_b), 64'd0);

    // Saturation: period 4, gate 255 -> closing edge at 256 clamps to 255
    per = 4;
    repeat (20) @(negedge clk_200M);
    ch_en_b = 2'b01; gate_b = 8'd255;
    pulse_b(2'b01);
    expect_res("sat", 1'b1, 700, 64'd0, 64'd64, 64'd255, 64'd1, t);
    @(negedge clk_200M);
    check("sat_rearm", 64'(busy_b), 64'b01);

    // Reset in the middle of a window
    repeat (100) @(negedge clk_200M);
    rst = 1'b1;
    @(negedge clk_200M);
    check("mrst_busy", 64'(busy_b), 64'd0);
    check("mrst_valid", 64'(res_b.res_valid), 64'd0);
    check("mrst_sig", 64'(res_b.res_sig_cnt), 64'd0);
    check("mrst_ref", 64'(res_b.res_ref_cnt), 64'd0);
    check("mrst_flags", 64'(res_b.res_flags), 64'd0);
    rst = 1'b0;
    vcnt = 0;
    repeat (600) begin
      @(negedge clk_200M);
      if (res_b.res_valid) vcnt++;
    end
    check("mrst_no_result", 64'(vcnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
